// File: rtl/sfft_pkg.sv
// sfft_pkg -- shared definitions for the sliding FFT front end.
//
// Contents:
//   - Default widths: NFFT, NFFT_LOG2, INPUT_WIDTH, OUTPUT_WIDTH, FRAC_BITS.
//   - cplx_t: signed complex word (re, im), each OUTPUT_WIDTH bits wide.
//   - TW_COS / TW_SIN: Q7 twiddle tables, rounded to nearest.
//   - bit_rev(): bit-reverse helper used by the load stage.
//
// Twiddle tables:
//   - They cover one half circle of a 16-point transform.
//   - An NFFT-point design (NFFT = 4, 8 or 16) reads them with a stride of
//     16/NFFT.
//   - The twiddle for k is exp(-j*2*pi*k/NFFT) = TW_COS[k*stride] - j*TW_SIN[k*stride].
//   - The tables are written for FRAC_BITS = 7.
package sfft_pkg;

  localparam int NFFT         = 8;
  localparam int NFFT_LOG2    = 3;
  localparam int INPUT_WIDTH  = 24;
  localparam int OUTPUT_WIDTH = 32;
  localparam int FRAC_BITS    = 7;

  // One extra magnitude bit so that +1.0 (128) is representable.
  localparam int TW_WIDTH   = FRAC_BITS + 2;
  localparam int TW_TABLE_N = 16;
  localparam int TW_IDX_W   = $clog2(TW_TABLE_N / 2);

  typedef struct packed {
    logic signed [OUTPUT_WIDTH-1:0] re;
    logic signed [OUTPUT_WIDTH-1:0] im;
  } cplx_t;

  localparam logic signed [TW_WIDTH-1:0] TW_COS [TW_TABLE_N/2] = '{
    9'sd128, 9'sd118, 9'sd91, 9'sd49, 9'sd0, -9'sd49, -9'sd91, -9'sd118
  };

  localparam logic signed [TW_WIDTH-1:0] TW_SIN [TW_TABLE_N/2] = '{
    9'sd0, 9'sd49, 9'sd91, 9'sd118, 9'sd128, 9'sd118, 9'sd91, 9'sd49
  };

  function automatic int unsigned bit_rev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sfft_butterfly.sv
// sfft_butterfly -- combinational radix-2 DIT butterfly.
//
// Function:
//   top = a + W*b
//   bot = a - W*b
//   where W = exp(-j*2*pi*tw_idx/NFFT).
//
// Ports:
//   a_re, a_im   in   upper operand
//   b_re, b_im   in   lower operand (the one rotated by the twiddle)
//   tw_idx       in   twiddle exponent, 0..NFFT/2-1
//   top_re/im    out  a + W*b
//   bot_re/im    out  a - W*b
//
// Arithmetic:
//   - W = 1 and W = -j are applied exactly, by pass-through or by swap and
//     negate.
//   - For every other twiddle, each of the four partial products is
//     arithmetic-shifted right by FRAC_BITS on its own.
//   - All sums are OUTPUT_WIDTH bits and wrap on overflow.
//
// Build option:
//   SFFT_TWIDDLE_ROUND_EN  If defined, adds 2^(FRAC_BITS-1) to each product
//                          before the shift (round half up).
//                          If undefined, the shift truncates toward -inf.
module sfft_butterfly #(
  parameter int NFFT         = sfft_pkg::NFFT,
  parameter int NFFT_LOG2    = sfft_pkg::NFFT_LOG2,
  parameter int OUTPUT_WIDTH = sfft_pkg::OUTPUT_WIDTH,
  parameter int FRAC_BITS    = sfft_pkg::FRAC_BITS
) (
  input  logic signed [OUTPUT_WIDTH-1:0] a_re,
  input  logic signed [OUTPUT_WIDTH-1:0] a_im,
  input  logic signed [OUTPUT_WIDTH-1:0] b_re,
  input  logic signed [OUTPUT_WIDTH-1:0] b_im,
  input  logic        [NFFT_LOG2-2:0]    tw_idx,
  output logic signed [OUTPUT_WIDTH-1:0] top_re,
  output logic signed [OUTPUT_WIDTH-1:0] top_im,
  output logic signed [OUTPUT_WIDTH-1:0] bot_re,
  output logic signed [OUTPUT_WIDTH-1:0] bot_im
);
  import sfft_pkg::*;

  localparam int PW       = OUTPUT_WIDTH + TW_WIDTH;
  localparam int TAB_STEP = TW_TABLE_N / NFFT;
  localparam logic [NFFT_LOG2-2:0] QUARTER_IDX = (NFFT_LOG2-1)'(NFFT / 4);

  logic        [TW_IDX_W-1:0]     tab_idx;
  logic signed [TW_WIDTH-1:0]     tw_c;
  logic signed [TW_WIDTH-1:0]     tw_s;
  logic signed [PW-1:0]           p_rc;
  logic signed [PW-1:0]           p_is;
  logic signed [PW-1:0]           p_ic;
  logic signed [PW-1:0]           p_rs;
  logic signed [OUTPUT_WIDTH-1:0] w_re;
  logic signed [OUTPUT_WIDTH-1:0] w_im;

  function automatic logic signed [OUTPUT_WIDTH-1:0] scale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
`ifdef SFFT_TWIDDLE_ROUND_EN
    t = p + PW'(2 ** (FRAC_BITS - 1));
`else
    t = p;
`endif
    t = t >>> FRAC_BITS;
    return t[OUTPUT_WIDTH-1:0];
  endfunction

  always_comb begin
    tab_idx = TW_IDX_W'(int'(tw_idx) * TAB_STEP);
    tw_c    = TW_COS[tab_idx];
    tw_s    = TW_SIN[tab_idx];

    // (br + j*bi) * (c - j*s) = (br*c + bi*s) + j*(bi*c - br*s)
    p_rc = b_re * tw_c;
    p_is = b_im * tw_s;
    p_ic = b_im * tw_c;
    p_rs = b_re * tw_s;

    if (tw_idx == '0) begin
      w_re = b_re;
      w_im = b_im;
    end else if (tw_idx == QUARTER_IDX) begin
      // (br + j*bi) * (-j) = bi - j*br
      w_re = b_im;
      w_im = -b_re;
    end else begin
      w_re = scale(p_rc) + scale(p_is);
      w_im = scale(p_ic) - scale(p_rs);
    end

    top_re = a_re + w_re;
    top_im = a_im + w_im;
    bot_re = a_re - w_re;
    bot_im = a_im - w_im;
  end

endmodule

// File: rtl/sfft_pipeline.sv
// sfft_pipeline -- sliding FFT front end.
//
// Function:
//   - Keeps the last NFFT audio samples in a window; w[0] is the newest.
//   - Each advance shifts one sample into the window and recomputes an
//     NFFT-point radix-2 DIT FFT over it.
//   - NFFT/2 butterflies are shared by all stages, one stage per clock.
//
// Ports:
//   clk                in   clock, rising edge
//   reset              in   synchronous, active-high
//   SampleAmplitudeIn  in   signed sample, captured when advanceSignal is high
//   advanceSignal      in   shift the sample in and (re)start the transform
//   SFFT_Out[2k]       out  Re X[k], for k = 0..NFFT/2-1
//   SFFT_Out[2k+1]     out  Im X[k], for k = 0..NFFT/2-1
//   OutputValid        out  high while SFFT_Out matches the current window
//
// Timing (advance accepted at edge E):
//   E                  window shifts, OutputValid drops
//   E+1                LOAD
//   E+2 .. E+1+LOG2    butterfly stages
//   E+2+LOG2           DONE: outputs update, OutputValid rises
//   An advance accepted in any state restarts the sequence from LOAD.
//
// Build option:
//   SFFT_TWIDDLE_ROUND_EN  Selects round-half-up twiddle products
//                          (see sfft_butterfly).
module sfft_pipeline #(
  parameter int NFFT         = sfft_pkg::NFFT,
  parameter int NFFT_LOG2    = sfft_pkg::NFFT_LOG2,
  parameter int INPUT_WIDTH  = sfft_pkg::INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = sfft_pkg::OUTPUT_WIDTH,
  parameter int FRAC_BITS    = sfft_pkg::FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [INPUT_WIDTH-1:0]  SampleAmplitudeIn,
  input  logic                           advanceSignal,
  output logic signed [OUTPUT_WIDTH-1:0] SFFT_Out [NFFT],
  output logic                           OutputValid
);
  import sfft_pkg::*;

  localparam int NB = NFFT / 2;
  localparam int SW = $clog2(NFFT_LOG2);

  typedef enum logic [1:0] {IDLE, LOAD, STAGE, DONE} state_t;

  state_t                         state_reg;
  logic        [SW-1:0]           stage_reg;
  logic signed [OUTPUT_WIDTH-1:0] window_reg [NFFT];
  cplx_t                          work_reg   [NFFT];

  // Operand/result indices for each butterfly in the current stage.
  logic        [NFFT_LOG2-1:0]    i_idx  [NB];
  logic        [NFFT_LOG2-1:0]    j_idx  [NB];
  logic        [NFFT_LOG2-2:0]    tw_idx [NB];
  logic signed [OUTPUT_WIDTH-1:0] top_re [NB];
  logic signed [OUTPUT_WIDTH-1:0] top_im [NB];
  logic signed [OUTPUT_WIDTH-1:0] bot_re [NB];
  logic signed [OUTPUT_WIDTH-1:0] bot_im [NB];

  // Stage s works on groups of span 2*half, where half = 2^s.
  // Butterfly b handles position pos = b mod half of group b / half.
  // Its twiddle exponent is pos * NFFT / (2*half).
  always_comb begin
    int unsigned half;
    int unsigned pos;
    int unsigned base;
    half = 32'd1 << stage_reg;
    for (int b = 0; b < NB; b++) begin
      pos       = int'(b) & (half - 1);
      base      = (int'(b) >> stage_reg) << (int'(stage_reg) + 1);
      i_idx[b]  = NFFT_LOG2'(base + pos);
      j_idx[b]  = NFFT_LOG2'(base + pos + half);
      tw_idx[b] = (NFFT_LOG2-1)'(pos << (NFFT_LOG2 - 1 - int'(stage_reg)));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bfly
      sfft_butterfly #(
        .NFFT         (NFFT),
        .NFFT_LOG2    (NFFT_LOG2),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .FRAC_BITS    (FRAC_BITS)
      ) u_bfly (
        .a_re   (work_reg[i_idx[gi]].re),
        .a_im   (work_reg[i_idx[gi]].im),
        .b_re   (work_reg[j_idx[gi]].re),
        .b_im   (work_reg[j_idx[gi]].im),
        .tw_idx (tw_idx[gi]),
        .top_re (top_re[gi]),
        .top_im (top_im[gi]),
        .bot_re (bot_re[gi]),
        .bot_im (bot_im[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      stage_reg   <= '0;
      OutputValid <= 1'b0;
      for (int n = 0; n < NFFT; n++) begin
        window_reg[n] <= '0;
        work_reg[n]   <= '0;
        SFFT_Out[n]   <= '0;
      end
    end else if (advanceSignal) begin
      // An advance wins over any in-flight work; the partial result is dropped.
      for (int n = 1; n < NFFT; n++) begin
        window_reg[n] <= window_reg[n-1];
      end
      window_reg[0] <= {{(OUTPUT_WIDTH-INPUT_WIDTH){SampleAmplitudeIn[INPUT_WIDTH-1]}},
                        SampleAmplitudeIn};
      OutputValid   <= 1'b0;
      state_reg     <= LOAD;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= IDLE;
        end
        LOAD: begin
          for (int n = 0; n < NFFT; n++) begin
            work_reg[n].re <= window_reg[NFFT_LOG2'(bit_rev(n, NFFT_LOG2))];
            work_reg[n].im <= '0;
          end
          stage_reg <= '0;
          state_reg <= STAGE;
        end
        STAGE: begin
          for (int b = 0; b < NB; b++) begin
            work_reg[i_idx[b]].re <= top_re[b];
            work_reg[i_idx[b]].im <= top_im[b];
            work_reg[j_idx[b]].re <= bot_re[b];
            work_reg[j_idx[b]].im <= bot_im[b];
          end
          if (stage_reg == SW'(NFFT_LOG2 - 1)) begin
            state_reg <= DONE;
          end else begin
            stage_reg <= stage_reg + 1'b1;
          end
        end
        DONE: begin
          for (int k = 0; k < NB; k++) begin
            SFFT_Out[2*k]   <= work_reg[k].re;
            SFFT_Out[2*k+1] <= work_reg[k].im;
          end
          OutputValid <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_pipeline.sv
// tb_sfft_pipeline -- directed self-checking bench for sfft_pipeline (NFFT=8).
// Expected values are hand-computed from the DFT of each window.
// The one build-dependent bin follows SFFT_TWIDDLE_ROUND_EN.
module tb_sfft_pipeline;

  logic                clk = 1'b0;
  logic                reset;
  logic                adv;
  logic signed [23:0]  sample;
  logic signed [31:0]  sfft_out [8];
  logic                valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sfft_pipeline dut (
    .clk               (clk),
    .reset             (reset),
    .SampleAmplitudeIn (sample),
    .advanceSignal     (adv),
    .SFFT_Out          (sfft_out),
    .OutputValid       (valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [31:0] obs, input int exp_v);
    n_checks++;
    assert ((obs >= exp_v - 4) && (obs <= exp_v + 4))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +-4", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bin(input string tag, input int k, input int re, input int im);
    chk($sformatf("%s_re%0d", tag, k), sfft_out[2*k], re);
    chk($sformatf("%s_im%0d", tag, k), sfft_out[2*k+1], im);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_out%0d", tag, i), sfft_out[i], 0);
    end
  endtask

  // Called just after the accepting edge E.
  // Checks that OutputValid is low through E+4 and high at E+5.
  task automatic wait_result(input string tag);
    chk({tag, "_valid_e0"}, {31'd0, valid}, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("%s_valid_e%0d", tag, c), {31'd0, valid}, 0);
    end
    tick();
    chk({tag, "_valid_e5"}, {31'd0, valid}, 1);
  endtask

  task automatic advance_one(input int v);
    sample = 24'(v);
    adv    = 1'b1;
    tick();
    adv    = 1'b0;
    $display("advance sample=%0d", v);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset pulse");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int samples [8];
    samples = '{61, 77, 90, 6, 33, 23, 85, 11};
    reset  = 1'b1;
    adv    = 1'b0;
    sample = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_all_zero($sformatf("idle%0d", c));
    end
    $display("idle 20 cycles checked");

    // 2: eight spaced advances
    for (int i = 0; i < 7; i++) begin
      advance_one(samples[i]);
      for (int c = 0; c < 10; c++) tick();
    end
    advance_one(samples[7]);
    wait_result("seq");
    chk_bin("seq", 0, 386, 0);
    chk_bin("seq", 2, -83, -81);
    chk_tol("seq_re1", sfft_out[2], 21);
    chk_tol("seq_im1", sfft_out[3], 77);
    chk_tol("seq_re3", sfft_out[6], -11);
    chk_tol("seq_im3", sfft_out[7], -31);
    $display("result seq: bin0=(%0d,%0d) bin1=(%0d,%0d) bin2=(%0d,%0d) bin3=(%0d,%0d)",
             sfft_out[0], sfft_out[1], sfft_out[2], sfft_out[3],
             sfft_out[4], sfft_out[5], sfft_out[6], sfft_out[7]);

    // 3: single impulse after reset
    do_reset();
    advance_one(100);
    wait_result("imp");
    for (int k = 0; k < 4; k++) chk_bin("imp", k, 100, 0);
    $display("result imp: bin0=(%0d,%0d)", sfft_out[0], sfft_out[1]);

    // 4: restart two cycles into a computation; window becomes 30,20,100,0...
    advance_one(20);
    chk("abort_valid_fall", {31'd0, valid}, 0);
    tick();
    chk("abort_valid_mid", {31'd0, valid}, 0);
    advance_one(30);
    wait_result("abort");
    chk_bin("abort", 0, 150, 0);
    chk_bin("abort", 1, 44, -114);
    chk_bin("abort", 2, -70, -20);
`ifdef SFFT_TWIDDLE_ROUND_EN
    chk_bin("abort", 3, 16, 86);
`else
    chk_bin("abort", 3, 15, 86);
`endif
    $display("result abort: bin3=(%0d,%0d)", sfft_out[6], sfft_out[7]);

    // 5: reset while a stage is running
    advance_one(50);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("midrst");
    $display("reset during stage checked");
    advance_one(-5);
    wait_result("neg");
    for (int k = 0; k < 4; k++) chk_bin("neg", k, -5, 0);
    $display("result neg: bin0=(%0d,%0d)", sfft_out[0], sfft_out[1]);

    // 6: advance held high for three cycles; window becomes 7,7,7,0...
    do_reset();
    sample = 24'sd7;
    adv    = 1'b1;
    tick();
    tick();
    tick();
    adv    = 1'b0;
    $display("advance held 3 cycles sample=7");
    wait_result("hold");
    chk_bin("hold", 0, 21, 0);
    chk_bin("hold", 2, 0, -7);
    $display("result hold: bin0=(%0d,%0d)", sfft_out[0], sfft_out[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
